// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, result held until consumed or redirected.
// Optional redirect counter built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  RESET_PC = {N{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [N-1:0]  pc_out,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]   redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [N-1:0]  pc_out_q, pc_out_d;
  logic [N-1:0]  redirect_tgt;

  // Targets are always word aligned.
  assign redirect_tgt = redirect_pc & ~N'(3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      pc_out_q <= {N{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    imem_req = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = redirect_tgt;
        end else begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response that overlaps or follows a redirect belongs to the old path.
        if (imem_rvalid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
          if (redirect) pc_d = redirect_tgt;
        end else if (redirect) begin
          pc_d   = redirect_tgt;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_q + N'(4);
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt <= 16'd0;
    end else if (redirect && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] redirect_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Advance to the next cycle and drive that cycle's inputs.
  task automatic cyc(input logic rdr, input logic [31:0] rpc, input logic rdy,
                     input logic rv, input logic [31:0] rd);
    @(negedge clk);
    redirect    = rdr;
    redirect_pc = rpc;
    instr_ready = rdy;
    imem_rvalid = rv;
    imem_rdata  = rd;
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release, inputs idle.
  task automatic do_reset;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || pc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc_out=%h, expected 0/0/0", instr_valid, instr, pc_out);
    end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_req: req=%b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
    end
    do_reset;
    d = $urandom;
    cyc(1'b0, 32'd0, 1'b0, 1'b1, d);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (instr_valid !== 1'b1 || instr !== d) begin
      n_fail++;
      $display("FAIL reset_prep_hold: valid=%b instr=%h, expected 1 %h", instr_valid, instr, d);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || pc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_in_hold: valid=%b instr=%h pc_out=%h, expected 0/0/0", instr_valid, instr, pc_out);
    end
  endtask

  task automatic test_basic_loop;
    logic [31:0] d;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_req%0d: req=%b addr=%h valid=%b, expected 1 %h 0", k, imem_req, imem_addr, instr_valid, 32'(4 * k));
      end
      d = $urandom;
      cyc(1'b0, 32'd0, 1'b1, 1'b1, d);
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_wait%0d: req=%b valid=%b, expected 0 0", k, imem_req, instr_valid);
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== d || pc_out !== 32'(4 * k) || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_hold%0d: valid=%b instr=%h pc_out=%h req=%b, expected 1 %h %h 0", k, instr_valid, instr, pc_out, imem_req, d, 32'(4 * k));
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end
  endtask

  task automatic test_stall;
    logic [31:0] d;
    do_reset;
    cyc(1'b1, 32'h12, 1'b0, 1'b1, 32'h1234_5678);
    n_cmp++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_redirect_rvalid: req=%b valid=%b, expected 0 0", imem_req, instr_valid);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req: req=%b addr=%h valid=%b, expected 1 00000010 0", imem_req, imem_addr, instr_valid);
    end
    d = $urandom;
    cyc(1'b0, 32'd0, 1'b0, 1'b1, d);
    for (int j = 0; j < 5; j++) begin
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== d || pc_out !== 32'h10 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b instr=%h pc_out=%h req=%b, expected 1 %h 00000010 0", j, instr_valid, instr, pc_out, imem_req, d);
      end
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_next: req=%b addr=%h valid=%b, expected 1 00000014 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rwait_req: req=%b, expected 0", imem_req);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL rwait_drop: valid=%b req=%b addr=%h, expected 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_hold;
    logic [31:0] d;
    do_reset;
    d = $urandom;
    cyc(1'b0, 32'd0, 1'b0, 1'b1, d);
    cyc(1'b1, 32'h43, 1'b1, 1'b0, 32'd0);
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 32'd0 || instr !== d) begin
      n_fail++;
      $display("FAIL rhold_hold: valid=%b pc_out=%h instr=%h, expected 1 00000000 %h", instr_valid, pc_out, instr, d);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL rhold_next: valid=%b req=%b addr=%h, expected 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_reset;
    logic [31:0] d;
    do_reset;
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req: req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
    end
    d = $urandom;
    cyc(1'b0, 32'd0, 1'b0, 1'b1, d);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    n_cmp++;
    if (instr_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instr !== d) begin
      n_fail++;
      $display("FAIL wrap_hold: valid=%b pc_out=%h instr=%h, expected 1 fffffffc %h", instr_valid, pc_out, instr, d);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL midwait_reset: valid=%b req=%b addr=%h, expected 0 1 00000000", instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rvalid_ignored: valid=%b req=%b, expected 0 0", instr_valid, imem_req);
    end
  endtask

  task automatic test_perf;
`ifdef FETCH_CTRL_PERF_EN
    do_reset;
    n_cmp++;
    if (redirect_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_reset: cnt=%0d, expected 0", redirect_cnt);
    end
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 32'(32'h20 + 16 * j), 1'b0, 1'b0, 32'd0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
    n_cmp++;
    if (redirect_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL perf_count: cnt=%0d, expected 3", redirect_cnt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (redirect_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_clear: cnt=%0d, expected 0", redirect_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
`endif
  endtask

  // Model tracks transactions: the address the next fetch must use, the one open request
  // and whether a redirect has made it stale, and the instruction currently offered.
  task automatic test_random;
    logic        outstanding, tainted, ev, exp_req, rdr, rdy, rv;
    logic [31:0] enext, einstr, epc, raddr, rpc, rd;
    outstanding = 1'b0; tainted = 1'b0; ev = 1'b0;
    enext = 32'd0; einstr = 32'd0; epc = 32'd0; raddr = 32'd0;
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      rdr = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      rv  = outstanding ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rd  = $urandom;
      redirect = rdr; redirect_pc = rpc; instr_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      #1;
      exp_req = !outstanding && !ev && !rdr;
      n_cmp++;
      if (imem_req !== exp_req) begin
        n_fail++;
        $display("FAIL rand_req@%0d: req=%b, expected %b", i, imem_req, exp_req);
      end
      if (exp_req && imem_req === 1'b1) begin
        n_cmp++;
        if (imem_addr !== enext) begin
          n_fail++;
          $display("FAIL rand_addr@%0d: addr=%h, expected %h", i, imem_addr, enext);
        end
      end
      n_cmp++;
      if (instr_valid !== ev || (ev && (instr !== einstr || pc_out !== epc))) begin
        n_fail++;
        $display("FAIL rand_out@%0d: valid=%b instr=%h pc_out=%h, expected %b %h %h", i, instr_valid, instr, pc_out, ev, einstr, epc);
      end
      if (ev && (rdr || rdy)) begin
        ev = 1'b0;
        if (!rdr) enext = epc + 32'd4;
      end
      if (rdr) enext = rpc & ~32'd3;
      if (exp_req) begin
        outstanding = 1'b1;
        tainted     = 1'b0;
        raddr       = enext;
      end else if (outstanding && rv) begin
        outstanding = 1'b0;
        if (!tainted && !rdr) begin
          ev = 1'b1; einstr = rd; epc = raddr;
        end
      end else if (outstanding && rdr) begin
        tainted = 1'b1;
      end
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_basic_loop;
    test_stall;
    test_redirect_wait;
    test_redirect_hold;
    test_wrap_reset;
    test_perf;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 32: PC and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-006 imem_addr  output  N  fetch address; valid while imem_req=1.
REQ-007 imem_rvalid  input  1  read data returned this cycle.
REQ-008 imem_rdata  input  32  returned instruction word.
REQ-009 instr_valid  output  1  instr/pc_out hold a valid fetched instruction.
REQ-010 instr  output  32  fetched instruction.
REQ-011 pc_out  output  N  address of instr.
REQ-012 instr_ready  input  1  downstream consumes instr when instr_valid=1.
REQ-013 redirect  input  1  taken branch/JAL/JALR: discard in-flight work and refetch.
REQ-014 redirect_pc  input  N  redirect target; bits [1:0] forced to 0 internally.

Function
REQ-015 The block SHALL implement a three-state FSM: FETCH, WAIT, HOLD.
REQ-016 FETCH: imem_req=1 and imem_addr=pc combinationally unless redirect=1; with redirect=0, next state WAIT.
REQ-017 FETCH with redirect=1: imem_req=0, pc <= redirect_pc, state stays FETCH.
REQ-018 WAIT: imem_req=0; imem_rvalid=1 with drop=0 registers instr<=imem_rdata, pc_out<=pc, instr_valid<=1, next HOLD.
REQ-019 WAIT with imem_rvalid=1 and drop=1: data discarded, drop<=0, next FETCH.
REQ-020 WAIT with redirect=1: pc <= redirect_pc, drop<=1 (unless rvalid in same cycle, in which case the data is discarded and next state is FETCH with drop=0).
REQ-021 HOLD: instr_valid, instr, pc_out stable; instr_ready=1 sets pc <= pc+4, instr_valid<=0, next FETCH.
REQ-022 HOLD with redirect=1: pc <= redirect_pc, instr_valid<=0, next FETCH; redirect wins over simultaneous instr_ready (pc+4 not applied).
REQ-023 pc+4 SHALL wrap modulo 2^N (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 imem_rvalid outside WAIT SHALL be ignored.
REQ-025 Minimum fetch loop: req cycle, rvalid next cycle, instr_valid following cycle; with instr_ready held 1, one instruction per 3 cycles.
REQ-026 At most one outstanding imem request at any time.

Reset
REQ-027 reset=1 SHALL immediately force: state FETCH, pc=RESET_PC, drop=0, instr_valid=0, instr=0, pc_out=0.
REQ-028 Reset mid-WAIT abandons the request; a late imem_rvalid after reset release is ignored per REQ-024 unless it arrives after the next request.
REQ-029 First imem_req=1 with imem_addr=RESET_PC SHALL appear in the first cycle after reset deasserts.

Configuration
REQ-030 Macro FETCH_CTRL_PERF_EN defined: adds output redirect_cnt[15:0], cleared by reset, incremented on every cycle with redirect=1, saturating at 16'hFFFF.
REQ-031 Macro FETCH_CTRL_PERF_EN undefined: redirect_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset release, memory returns rvalid 1 cycle after req, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; pc_out matches each; instr_valid one cycle per 3.
REQ-033 In HOLD with pc_out=0x10, hold instr_ready=0 for 5 cycles -> instr/pc_out stable, no imem_req; then ready=1 -> next imem_addr=0x14.
REQ-034 redirect=1, redirect_pc=0x100 during WAIT, rvalid next cycle -> that data dropped, instr_valid stays 0, next imem_addr=0x100.
REQ-035 HOLD with instr_ready=1 and redirect=1, redirect_pc=0x43 -> next imem_addr=0x40, not pc+4.
REQ-036 pc at 0xFFFF_FFFC consumed -> next imem_addr=0x0; reset pulse mid-WAIT -> instr_valid=0 immediately, next req at RESET_PC.
REQ-037 With FETCH_CTRL_PERF_EN, three single-cycle redirects -> redirect_cnt=3; reset -> 0.
